// File: rtl/branch_cond_unit.sv
// Branch condition unit: counts compares in flight, latches returned comparator flags,
// and resolves one branch at a time over a valid/ready handshake once all older compares return.
module branch_cond_unit #(
  parameter int ADDR_W  = 32,
  parameter int PEND_W  = 3,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmp_issue,
  input  logic              flag_valid,
  input  logic              flag_equal,
  input  logic              flag_z,
  input  logic              flag_n,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_taken,
  output logic [ADDR_W-1:0] res_target,
  output logic              res_err,
  output logic              err_sticky
);

  localparam int                WCNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [PEND_W-1:0]   r_pend;
  logic [PEND_W-1:0]   w_pend_next;
  logic                w_cnt_err;
  logic                r_flag_eq;
  logic                r_flag_z;
  logic                r_flag_n;
  logic [2:0]          r_cond;
  logic [ADDR_W-1:0]   r_target;
  logic [WCNT_W-1:0]   r_wait;
  logic                r_res_valid;
  logic                r_res_taken;
  logic                r_res_err;
  logic                r_err_sticky;
  logic                w_accept;
  logic                w_resolve;
  logic                w_timeout;
  logic                w_cond_met;

  assign br_ready   = (r_state == S_IDLE);
  assign w_accept   = br_valid && (r_state == S_IDLE);
  assign res_valid  = r_res_valid;
  assign res_taken  = r_res_taken;
  assign res_target = r_target;
  assign res_err    = r_res_err;
  assign err_sticky = r_err_sticky;

  // Simultaneous issue and return cancel; underflow and overflow hold the count and flag an error.
  always_comb begin
    w_pend_next = r_pend;
    w_cnt_err   = 1'b0;
    if (cmp_issue && !flag_valid) begin
      if (r_pend == PEND_MAX) w_cnt_err = 1'b1;
      else                    w_pend_next = r_pend + 1'b1;
    end else if (flag_valid && !cmp_issue) begin
      if (r_pend == '0) w_cnt_err = 1'b1;
      else              w_pend_next = r_pend - 1'b1;
    end
  end

  always_comb begin
    w_cond_met = 1'b0;
    case (r_cond)
      3'b000:  w_cond_met = 1'b1;
      3'b001:  w_cond_met = r_flag_eq;
      3'b010:  w_cond_met = !r_flag_eq;
      3'b011:  w_cond_met = r_flag_z;
      3'b100:  w_cond_met = !r_flag_z;
      3'b101:  w_cond_met = r_flag_n;
      3'b110:  w_cond_met = !r_flag_n;
      default: w_cond_met = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_resolve    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: if (br_valid) w_state_next = S_WAIT;
      S_WAIT: begin
        // Registered count covers compares issued after the accept as well.
        if (r_pend == '0) begin
          w_state_next = S_RESP;
          w_resolve    = 1'b1;
        end else if (r_wait == WAIT_LAST) begin
          w_state_next = S_RESP;
          w_timeout    = 1'b1;
        end
      end
      S_RESP: if (res_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pend       <= '0;
      r_flag_eq    <= 1'b0;
      r_flag_z     <= 1'b0;
      r_flag_n     <= 1'b0;
      r_cond       <= 3'b000;
      r_target     <= '0;
      r_wait       <= '0;
      r_res_valid  <= 1'b0;
      r_res_taken  <= 1'b0;
      r_res_err    <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_pend_next;
      if (w_cnt_err) r_err_sticky <= 1'b1;
      if (flag_valid) begin
        r_flag_eq <= flag_equal;
        r_flag_z  <= flag_z;
        r_flag_n  <= flag_n;
      end
      if (w_accept) begin
        r_cond      <= br_cond;
        r_target    <= br_target;
        r_wait      <= '0;
        r_res_taken <= 1'b0;
        r_res_err   <= 1'b0;
      end
      if (r_state == S_WAIT) r_wait <= r_wait + 1'b1;
      if (w_resolve) begin
        r_res_valid <= 1'b1;
        r_res_taken <= w_cond_met;
      end
      if (w_timeout) begin
        r_res_valid <= 1'b1;
        r_res_taken <= 1'b0;
        r_res_err   <= 1'b1;
      end
      if ((r_state == S_RESP) && res_ready) r_res_valid <= 1'b0;
    end
  end

endmodule
